// File: rtl/game_flow_fsm.sv
`default_nettype none
// ============================================================================
// Module : game_flow_fsm
// Game phase sequencer: stage flow, lives, per-stage countdown, overlay reset.
// Rev    : 1.0  initial release
// ============================================================================
module game_flow_fsm #(
   parameter int CLKS_PER_SEC  = 50_000_000,
   parameter int STAGE_SECONDS = 60,
   parameter int NUM_LIVES     = 3
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       restart,
   input  logic       start_display_done,
   input  logic       stage_1_begin_done,
   input  logic       stage_2_begin_done,
   input  logic       stage_3_begin_done,
   input  logic       stage_1_end_display_done,
   input  logic       stage_2_end_display_done,
   input  logic       stage_3_end_display_done,
   input  logic       stage_cleared,
   input  logic       player_hit,
   output logic       wait_start,
   output logic       stage_1_begin,
   output logic       stage_2_begin,
   output logic       stage_3_begin,
   output logic       stage_1_done,
   output logic       stage_2_done,
   output logic       stage_3_done,
   output logic       win,
   output logic       game_over,
   output logic       play_enable,
   output logic [1:0] stage_num,
   output logic [2:0] lives,
   output logic [7:0] time_left,
   output logic       overlay_resetn
);

   localparam int PS_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;

   localparam logic [PS_W-1:0] C_PS_MAX = PS_W'(CLKS_PER_SEC - 1);
   localparam logic [2:0]      C_LIVES  = 3'(NUM_LIVES);
   localparam logic [7:0]      C_SECS   = 8'(STAGE_SECONDS);

   localparam logic [3:0] C_ST_WAIT      = 4'd0;
   localparam logic [3:0] C_ST_S1_BEGIN  = 4'd1;
   localparam logic [3:0] C_ST_S1_PLAY   = 4'd2;
   localparam logic [3:0] C_ST_S1_DONE   = 4'd3;
   localparam logic [3:0] C_ST_S2_BEGIN  = 4'd4;
   localparam logic [3:0] C_ST_S2_PLAY   = 4'd5;
   localparam logic [3:0] C_ST_S2_DONE   = 4'd6;
   localparam logic [3:0] C_ST_S3_BEGIN  = 4'd7;
   localparam logic [3:0] C_ST_S3_PLAY   = 4'd8;
   localparam logic [3:0] C_ST_S3_DONE   = 4'd9;
   localparam logic [3:0] C_ST_WIN       = 4'd10;
   localparam logic [3:0] C_ST_GAME_OVER = 4'd11;

   logic [3:0]      r_state;
   logic [3:0]      w_state_nxt;
   logic [6:0]      r_done_q;
   logic [2:0]      r_lives;
   logic [7:0]      r_time;
   logic [PS_W-1:0] r_presc;
   logic [1:0]      r_stage;
   logic [1:0]      w_stage_nxt;
   logic            r_ovr_resetn;

   // The start button belongs to the overlay controller.
   logic w_unused;
   assign w_unused = &{1'b0, start};

   // Bit 0: start display; bits 1..3: stage begin; bits 4..6: stage end display.
   logic [6:0] w_done_in;
   logic [6:0] w_rise;
   assign w_done_in = {stage_3_end_display_done, stage_2_end_display_done,
                       stage_1_end_display_done, stage_3_begin_done,
                       stage_2_begin_done, stage_1_begin_done, start_display_done};
   assign w_rise    = w_done_in & ~r_done_q;

   logic w_in_play;
   logic w_wrap;
   logic w_expire;
   logic w_enter_play;
   logic w_restart_go;
   assign w_in_play    = (r_state == C_ST_S1_PLAY) || (r_state == C_ST_S2_PLAY) ||
                         (r_state == C_ST_S3_PLAY);
   assign w_wrap       = w_in_play && (r_presc == C_PS_MAX);
   // A zero count inside PLAY only survives when a hit pre-empted the expiry edge.
   assign w_expire     = w_in_play && ((w_wrap && r_time == 8'd1) || r_time == 8'd0);
   assign w_enter_play = !w_in_play && ((w_state_nxt == C_ST_S1_PLAY) ||
                         (w_state_nxt == C_ST_S2_PLAY) || (w_state_nxt == C_ST_S3_PLAY));
   assign w_restart_go = ((r_state == C_ST_WIN) || (r_state == C_ST_GAME_OVER)) && restart;

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= C_ST_WAIT;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         C_ST_WAIT:     if (w_rise[0]) w_state_nxt = C_ST_S1_BEGIN;
         C_ST_S1_BEGIN: if (w_rise[1]) w_state_nxt = C_ST_S1_PLAY;
         C_ST_S2_BEGIN: if (w_rise[2]) w_state_nxt = C_ST_S2_PLAY;
         C_ST_S3_BEGIN: if (w_rise[3]) w_state_nxt = C_ST_S3_PLAY;
         C_ST_S1_PLAY, C_ST_S2_PLAY, C_ST_S3_PLAY: begin
            if (stage_cleared)
               w_state_nxt = r_state + 4'd1;
            else if (player_hit) begin
               if (r_lives == 3'd1) w_state_nxt = C_ST_GAME_OVER;
            end else if (w_expire)
               w_state_nxt = C_ST_GAME_OVER;
         end
         C_ST_S1_DONE:  if (w_rise[4]) w_state_nxt = C_ST_S2_BEGIN;
         C_ST_S2_DONE:  if (w_rise[5]) w_state_nxt = C_ST_S3_BEGIN;
         C_ST_S3_DONE:  if (w_rise[6]) w_state_nxt = C_ST_WIN;
         C_ST_WIN, C_ST_GAME_OVER: if (restart) w_state_nxt = C_ST_WAIT;
         default:       w_state_nxt = C_ST_WAIT;
      endcase
   end

   always_comb begin
      w_stage_nxt = r_stage;
      case (w_state_nxt)
         C_ST_WAIT:                                 w_stage_nxt = 2'd0;
         C_ST_S1_BEGIN, C_ST_S1_PLAY, C_ST_S1_DONE: w_stage_nxt = 2'd1;
         C_ST_S2_BEGIN, C_ST_S2_PLAY, C_ST_S2_DONE: w_stage_nxt = 2'd2;
         C_ST_S3_BEGIN, C_ST_S3_PLAY, C_ST_S3_DONE: w_stage_nxt = 2'd3;
         default:                                   w_stage_nxt = r_stage;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_done_q     <= '0;
         r_lives      <= C_LIVES;
         r_time       <= C_SECS;
         r_presc      <= '0;
         r_stage      <= 2'd0;
         r_ovr_resetn <= 1'b0;
      end else begin
         // Clearing on restart lets the regenerated sticky dones register as new rises.
         r_done_q     <= w_restart_go ? 7'd0 : w_done_in;
         r_ovr_resetn <= !w_restart_go;
         r_stage      <= w_stage_nxt;
         if (r_state == C_ST_WAIT && w_rise[0])
            r_lives <= C_LIVES;
         else if (w_in_play && !stage_cleared && player_hit)
            r_lives <= r_lives - 3'd1;
         if (w_enter_play) begin
            r_time  <= C_SECS;
            r_presc <= '0;
         end else if (w_in_play) begin
            if (w_wrap) begin
               r_presc <= '0;
               if (r_time != 8'd0) r_time <= r_time - 8'd1;
            end else begin
               r_presc <= r_presc + 1'b1;
            end
         end
      end
   end

   always_comb begin
      wait_start    = (r_state == C_ST_WAIT);
      stage_1_begin = (r_state == C_ST_S1_BEGIN);
      stage_2_begin = (r_state == C_ST_S2_BEGIN);
      stage_3_begin = (r_state == C_ST_S3_BEGIN);
      stage_1_done  = (r_state == C_ST_S1_DONE);
      stage_2_done  = (r_state == C_ST_S2_DONE);
      stage_3_done  = (r_state == C_ST_S3_DONE);
      win           = (r_state == C_ST_WIN);
      game_over     = (r_state == C_ST_GAME_OVER);
      play_enable   = w_in_play;
   end

   assign stage_num      = r_stage;
   assign lives          = r_lives;
   assign time_left      = r_time;
   assign overlay_resetn = r_ovr_resetn;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_fsm.sv
`default_nettype none
// tb_game_flow_fsm: directed game scenarios checked against a phase-level
// reference model every cycle, plus literal expectations at key points.
module tb_game_flow_fsm;

   localparam int CPS   = 4;
   localparam int SECS  = 3;
   localparam int LIVES = 2;

   logic clk = 1'b0;
   logic resetn, start, restart;
   logic sdd, b1, b2, b3, e1, e2, e3;
   logic stage_cleared, player_hit;
   logic wait_start, stage_1_begin, stage_2_begin, stage_3_begin;
   logic stage_1_done, stage_2_done, stage_3_done, win, game_over, play_enable;
   logic [1:0] stage_num;
   logic [2:0] lives;
   logic [7:0] time_left;
   logic overlay_resetn;

   always #5 clk = ~clk;

   game_flow_fsm #(.CLKS_PER_SEC(CPS), .STAGE_SECONDS(SECS), .NUM_LIVES(LIVES)) dut (
      .clk(clk), .resetn(resetn), .start(start), .restart(restart),
      .start_display_done(sdd),
      .stage_1_begin_done(b1), .stage_2_begin_done(b2), .stage_3_begin_done(b3),
      .stage_1_end_display_done(e1), .stage_2_end_display_done(e2),
      .stage_3_end_display_done(e3),
      .stage_cleared(stage_cleared), .player_hit(player_hit),
      .wait_start(wait_start), .stage_1_begin(stage_1_begin),
      .stage_2_begin(stage_2_begin), .stage_3_begin(stage_3_begin),
      .stage_1_done(stage_1_done), .stage_2_done(stage_2_done),
      .stage_3_done(stage_3_done), .win(win), .game_over(game_over),
      .play_enable(play_enable), .stage_num(stage_num), .lives(lives),
      .time_left(time_left), .overlay_resetn(overlay_resetn)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // Reference model: game phase plus stage number, cycles spent in PLAY.
   localparam int P_WAIT = 0, P_BEGIN = 1, P_PLAY = 2, P_DONE = 3, P_WIN = 4, P_OVER = 5;
   int         m_phase, m_stage, m_lives, m_cycles, m_ovr;
   bit         m_valid = 1'b0;
   logic [6:0] m_prev;

   always @(posedge clk) begin
      logic [6:0] d;
      logic [6:0] rise;
      d    = {e3, e2, e1, b3, b2, b1, sdd};
      rise = d & ~m_prev;
      if (!resetn) begin
         m_phase = P_WAIT; m_stage = 0; m_lives = LIVES; m_cycles = 0;
         m_ovr = 0; m_prev = '0; m_valid = 1'b1;
      end else begin
         m_prev = d;
         m_ovr  = 1;
         case (m_phase)
            P_WAIT:  if (rise[0]) begin m_phase = P_BEGIN; m_stage = 1; m_lives = LIVES; end
            P_BEGIN: if (rise[m_stage]) begin m_phase = P_PLAY; m_cycles = 0; end
            P_PLAY: begin
               m_cycles++;
               if (stage_cleared) m_phase = P_DONE;
               else if (player_hit) begin
                  m_lives--;
                  if (m_lives == 0) m_phase = P_OVER;
               end else if (m_cycles == SECS * CPS) m_phase = P_OVER;
            end
            P_DONE: if (rise[3 + m_stage]) begin
               if (m_stage == 3) m_phase = P_WIN;
               else begin m_phase = P_BEGIN; m_stage++; end
            end
            default: if (restart) begin
               m_phase = P_WAIT; m_stage = 0; m_ovr = 0; m_prev = '0;
            end
         endcase
      end
   end

   function automatic int exp_flags();
      logic [9:0] f;
      f = {m_phase == P_WAIT,
           m_phase == P_BEGIN && m_stage == 1, m_phase == P_BEGIN && m_stage == 2,
           m_phase == P_BEGIN && m_stage == 3,
           m_phase == P_DONE && m_stage == 1, m_phase == P_DONE && m_stage == 2,
           m_phase == P_DONE && m_stage == 3,
           m_phase == P_WIN, m_phase == P_OVER, m_phase == P_PLAY};
      return int'(f);
   endfunction

   always @(negedge clk) begin
      if (m_valid) begin
         chk("flags", int'({wait_start, stage_1_begin, stage_2_begin, stage_3_begin,
                            stage_1_done, stage_2_done, stage_3_done, win, game_over,
                            play_enable}), exp_flags());
         chk("stage_num", int'(stage_num), (m_phase == P_WAIT) ? 0 : m_stage);
         chk("lives", int'(lives), m_lives);
         chk("time_left", int'(time_left), SECS - m_cycles / CPS);
         chk("overlay_resetn", int'(overlay_resetn), m_ovr);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drop_dones();
      sdd = 0; b1 = 0; b2 = 0; b3 = 0; e1 = 0; e2 = 0; e3 = 0;
   endtask

   task automatic pulse_cleared();
      stage_cleared = 1; step(); stage_cleared = 0;
   endtask

   task automatic pulse_hit();
      player_hit = 1; step(); player_hit = 0;
   endtask

   task automatic do_restart();
      drop_dones(); step();
      restart = 1; step(); restart = 0;
      chk("restart_wait_start", int'(wait_start), 1);
      chk("restart_ovr_low", int'(overlay_resetn), 0);
      chk("restart_stage_num", int'(stage_num), 0);
      step();
      chk("restart_ovr_high", int'(overlay_resetn), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      resetn = 0; start = 0; restart = 0; stage_cleared = 0; player_hit = 0;
      drop_dones();
      step(); step();
      chk("rst_wait_start", int'(wait_start), 1);
      chk("rst_lives", int'(lives), 2);
      chk("rst_time", int'(time_left), 3);
      chk("rst_ovr", int'(overlay_resetn), 0);
      chk("rst_play", int'(play_enable), 0);
      resetn = 1; step();
      chk("rel_ovr", int'(overlay_resetn), 1);

      // Full flow; start_display_done held 10 cycles, stray stage-2 begin edge
      sdd = 1; step();
      chk("s1_begin", int'(stage_1_begin), 1);
      b2 = 1; step(); b2 = 0;
      chk("stray_done_ignored", int'(stage_1_begin), 1);
      repeat (8) step();
      chk("held_sdd_once", int'(stage_1_begin), 1);
      sdd = 0;
      b1 = 1; step();
      chk("s1_play", int'(play_enable), 1);
      chk("s1_stage_num", int'(stage_num), 1);
      pulse_cleared();
      chk("s1_done", int'(stage_1_done), 1);
      e1 = 1; step();
      chk("s2_begin", int'(stage_2_begin), 1);
      b2 = 1; step();
      chk("s2_play_stage", int'(stage_num), 2);
      pulse_cleared();
      chk("s2_done", int'(stage_2_done), 1);
      e2 = 1; step();
      chk("s3_begin", int'(stage_3_begin), 1);
      b3 = 1; step();
      chk("s3_play", int'(play_enable), 1);
      pulse_cleared();
      chk("s3_done", int'(stage_3_done), 1);
      e3 = 1; step();
      chk("win", int'(win), 1);
      chk("win_stage_num", int'(stage_num), 3);
      step();
      chk("win_holds", int'(win), 1);
      do_restart();

      // Timer expiry in stage 1
      sdd = 1; step();
      b1 = 1; step();
      repeat (3) step();
      chk("timer_c3", int'(time_left), 3);
      step();
      chk("timer_c4", int'(time_left), 2);
      repeat (4) step();
      chk("timer_c8", int'(time_left), 1);
      repeat (3) step();
      chk("timer_c11_live", int'(game_over), 0);
      step();
      chk("timer_c12_over", int'(game_over), 1);
      chk("timer_lives", int'(lives), 2);
      do_restart();

      // Hits in stage 2, including a hit coinciding with stage_cleared
      sdd = 1; step();
      b1 = 1; step();
      pulse_cleared();
      e1 = 1; step();
      b2 = 1; step();
      pulse_hit();
      chk("s2_hit_lives", int'(lives), 1);
      chk("s2_hit_play", int'(play_enable), 1);
      player_hit = 1; stage_cleared = 1; step();
      player_hit = 0; stage_cleared = 0;
      chk("hit_clear_done", int'(stage_2_done), 1);
      chk("hit_clear_lives", int'(lives), 1);
      resetn = 0; drop_dones(); step();
      chk("midrst_wait", int'(wait_start), 1);
      chk("midrst_lives", int'(lives), 2);
      resetn = 1; step();

      // Last life lost in stage 1
      sdd = 1; step();
      b1 = 1; step();
      pulse_hit();
      chk("d_hit1_lives", int'(lives), 1);
      pulse_hit();
      chk("d_over", int'(game_over), 1);
      chk("d_lives0", int'(lives), 0);
      pulse_hit();
      chk("d_hit_ignored", int'(lives), 0);
      chk("d_stage_hold", int'(stage_num), 1);
      do_restart();

      // Hit in WAIT_START is ignored; reset during S2_BEGIN
      pulse_hit();
      chk("wait_hit_ignored", int'(lives), 0);
      sdd = 1; step();
      chk("start_loads_lives", int'(lives), 2);
      b1 = 1; step();
      pulse_cleared();
      e1 = 1; step();
      chk("e_s2_begin", int'(stage_2_begin), 1);
      resetn = 0; drop_dones(); step();
      chk("e_rst_wait", int'(wait_start), 1);
      chk("e_rst_lives", int'(lives), 2);
      chk("e_rst_time", int'(time_left), 3);
      chk("e_rst_play", int'(play_enable), 0);
      resetn = 1; step(); step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/game_flow_fsm.md
# game_flow_fsm

Top-level game sequencer feeding the overlay/drawing controller. Drives a one-hot set of phase flags: `wait_start`, `stage_N_begin`, `stage_N_done`, `win`, `game_over`. Consumes that controller's completion feedback plus gameplay events (stage cleared, player hit). Owns the lives counter, the per-stage countdown timer, and a restart-driven reset pulse for the overlay controller, whose done flags are sticky.

## Interface
- CLKS_PER_SEC, default 50_000_000: clk cycles per timer second.
- STAGE_SECONDS, default 60: countdown loaded at each PLAY entry; 1..255.
- NUM_LIVES, default 3: lives loaded at game start; 1..7.
- clk  in  1  system clock (50 MHz).
- resetn  in  1  synchronous, active-low reset.
- start  in  1  player start button, level; passed through to the overlay controller, not used here.
- restart  in  1  return from WIN/GAME_OVER; level, sampled only in those states.
- start_display_done, stage_{1,2,3}_begin_done, stage_{1,2,3}_end_display_done  in  1 each  overlay feedback; sticky levels.
- stage_cleared  in  1  gameplay pulse: current stage objective met.
- player_hit  in  1  gameplay pulse: one life lost.
- wait_start, stage_{1,2,3}_begin, stage_{1,2,3}_done, win, game_over  out  1 each  one-hot phase flags.
- play_enable  out  1  high only in a PLAY state; gates gameplay logic.
- stage_num  out  2  0 = none, 1..3 = current stage.
- lives  out  3  remaining lives.
- time_left  out  8  remaining seconds of current stage.
- overlay_resetn  out  1  active-low reset for the overlay controller.

## Operation
- States (4-bit): WAIT_START, S1_BEGIN, S1_PLAY, S1_DONE, S2_BEGIN, S2_PLAY, S2_DONE, S3_BEGIN, S3_PLAY, S3_DONE, WIN, GAME_OVER.
- Phase flags decode combinationally from the state register. PLAY states assert no phase flag; they assert only play_enable.
- Every done input is registered. Transitions use the rising edge only (`in & ~in_q`), so sticky levels fire exactly once.
- WAIT_START -> S1_BEGIN on rise of start_display_done. On this transition, load lives = NUM_LIVES.
- SN_BEGIN -> SN_PLAY on rise of stage_N_begin_done. Load time_left = STAGE_SECONDS and clear the prescaler.
- SN_PLAY, in priority order:
  - stage_cleared -> SN_DONE.
  - Otherwise, player_hit with lives == 1 -> GAME_OVER, lives = 0.
  - Otherwise, player_hit -> lives - 1, stay.
  - Otherwise, time expiry -> GAME_OVER.
- Timer: the prescaler counts 0..CLKS_PER_SEC-1 only in PLAY. At wrap, time_left decrements. A decrement from 1 to 0 is expiry, taken the same edge.
- SN_DONE -> S(N+1)_BEGIN on rise of stage_N_end_display_done. S3_DONE -> WIN.
- WIN / GAME_OVER -> WAIT_START when restart = 1.
  - On this transition, overlay_resetn is low for exactly 1 cycle.
  - Edge-detect registers are cleared to 0, so regenerated done levels are seen as fresh rises.
- stage_num: 1 in S1_*, 2 in S2_*, 3 in S3_*. Holds its last value in WIN/GAME_OVER. 0 in WAIT_START.
- player_hit outside PLAY is ignored. stage_cleared outside PLAY is ignored.
- A done edge for a phase other than the current one is ignored (it is consumed into its edge register only).

## Timing
- Reset (resetn = 0 at an edge), all registered:
  - state = WAIT_START, so wait_start = 1 and all other flags = 0.
  - play_enable = 0, stage_num = 0, lives = NUM_LIVES, time_left = STAGE_SECONDS.
  - Prescaler = 0, edge registers = 0, overlay_resetn = 0.
- Cycle after reset release: overlay_resetn = 1.
- Reset mid-game behaves identically from any state.
- Latency: an input rising in cycle n (sampled at edge n) produces a new state and flags visible in cycle n+1.
- Timer: the first decrement occurs CLKS_PER_SEC cycles after PLAY entry. Expiry flags GAME_OVER visible STAGE_SECONDS*CLKS_PER_SEC cycles after PLAY entry.
- overlay_resetn pulse: low during the first cycle of WAIT_START after restart, high thereafter.

## Test plan
Use CLKS_PER_SEC = 4, STAGE_SECONDS = 3, NUM_LIVES = 2.
- Reset, then pulse each done signal in order, with stage_cleared in each PLAY -> flags step WAIT_START, S1_BEGIN, S1_PLAY (play_enable = 1, stage_num = 1), S1_DONE, …, S3_DONE, WIN. Each step takes 1 cycle after its input.
- Hold start_display_done high for 10 cycles -> exactly one transition to S1_BEGIN; no skip past S1_BEGIN.
- In S1_PLAY with no events -> time_left 3, 2, 1 at cycles 4, 8, then game_over = 1 at cycle 12 after entry. lives stays 2.
- In S2_PLAY, pulse player_hit -> lives = 1. Pulse player_hit again in the same cycle as stage_cleared -> S2_DONE, lives = 1.
- In S1_PLAY, pulse player_hit twice -> lives = 0 and game_over = 1 the cycle after the second hit. Then restart = 1 -> wait_start = 1, overlay_resetn low 1 cycle, stage_num = 0.
- Assert resetn = 0 during S2_BEGIN -> next cycle wait_start = 1, lives = 2, time_left = 3, play_enable = 0.
